// File: rtl/argmax_block.sv
// Per-node argmax classifier: scans the combination result memory one row per cycle and records the winning column.
// Optional feature macro ARGMAX_MAXVAL_OUT_EN adds max_value_out with each row's winning value.
module argmax_block #(
    parameter int NUM_OF_NODES   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int CLASS_BW       = $clog2(WEIGHT_COLS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      done_comb,
    input  logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_row_data [0:WEIGHT_COLS-1],
    output logic [WEIGHT_COLS-1:0]    index_for_read_row_out,
    output logic [CLASS_BW-1:0]       max_addi_answer [0:NUM_OF_NODES-1],
`ifdef ARGMAX_MAXVAL_OUT_EN
    output logic [DOT_PROD_WIDTH-1:0] max_value_out [0:NUM_OF_NODES-1],
`endif
    output logic                      done_argmax
);

    localparam int CNT_W = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_OF_NODES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             done_q, done_d;
    logic [CLASS_BW-1:0] class_q [0:NUM_OF_NODES-1];
    logic [CLASS_BW-1:0] class_d [0:NUM_OF_NODES-1];
`ifdef ARGMAX_MAXVAL_OUT_EN
    logic [DOT_PROD_WIDTH-1:0] maxval_q [0:NUM_OF_NODES-1];
    logic [DOT_PROD_WIDTH-1:0] maxval_d [0:NUM_OF_NODES-1];
`endif

    logic signed [DOT_PROD_WIDTH-1:0] best_val;
    logic [CLASS_BW-1:0]              best_idx;

    // Strict greater-than while scanning upward keeps the lowest column on ties.
    always_comb begin
        best_val = adj_fm_wm_row_data[0];
        best_idx = '0;
        for (int c = 1; c < WEIGHT_COLS; c++) begin
            if ($signed(adj_fm_wm_row_data[c]) > best_val) begin
                best_val = adj_fm_wm_row_data[c];
                best_idx = CLASS_BW'(c);
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        done_d    = done_q;
        class_d   = class_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
        maxval_d  = maxval_q;
`endif
        case (state_q)
            IDLE: begin
                row_cnt_d = '0;
                if (done_comb) state_d = SCAN;
            end
            SCAN: begin
                class_d[row_cnt_q] = best_idx;
`ifdef ARGMAX_MAXVAL_OUT_EN
                maxval_d[row_cnt_q] = best_val;
`endif
                if (row_cnt_q == LAST_ROW) begin
                    row_cnt_d = '0;
                    state_d   = DONE;
                    done_d    = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!done_comb) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                row_cnt_d = '0;
                done_d    = 1'b0;
            end
        endcase
    end

    // NOTE: the result arrays are small register files that must read 0 after reset, so they sit in the reset branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            done_q    <= 1'b0;
            for (int n = 0; n < NUM_OF_NODES; n++) begin
                class_q[n] <= '0;
`ifdef ARGMAX_MAXVAL_OUT_EN
                maxval_q[n] <= '0;
`endif
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            done_q    <= done_d;
            class_q   <= class_d;
`ifdef ARGMAX_MAXVAL_OUT_EN
            maxval_q  <= maxval_d;
`endif
        end
    end

    // Same-cycle read: the index selects the row whose data is compared this cycle.
    assign index_for_read_row_out = (state_q == SCAN) ? WEIGHT_COLS'(row_cnt_q) : '0;
    assign max_addi_answer        = class_q;
    assign done_argmax            = done_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
    assign max_value_out          = maxval_q;
`endif

endmodule

// File: tb/tb_argmax_block.sv
// Directed bench for argmax_block: drives a combinational row memory and checks scan timing and classes.
module tb_argmax_block;

    localparam int N = 6;
    localparam int C = 3;
    localparam int W = 16;

    logic          clk;
    logic          reset;
    logic          done_comb;
    logic [W-1:0]  row_data [0:C-1];
    logic [C-1:0]  index;
    logic [1:0]    classes [0:N-1];
    logic          done_argmax;
`ifdef ARGMAX_MAXVAL_OUT_EN
    logic [W-1:0]  max_vals [0:N-1];
`endif

    logic [W-1:0]  mem [0:N-1][0:C-1];

    int checks = 0;
    int errors = 0;

    argmax_block dut (
        .clk                    (clk),
        .reset                  (reset),
        .done_comb              (done_comb),
        .adj_fm_wm_row_data     (row_data),
        .index_for_read_row_out (index),
        .max_addi_answer        (classes),
`ifdef ARGMAX_MAXVAL_OUT_EN
        .max_value_out          (max_vals),
`endif
        .done_argmax            (done_argmax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < C; c++) begin
            row_data[c] = (int'(index) < N) ? mem[index][c] : '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        mem[r][0] = a;
        mem[r][1] = b;
        mem[r][2] = c;
    endtask

    task automatic load_basic();
        set_row(0, 16'd1, 16'd5, 16'd2);
        set_row(1, 16'd9, 16'd0, 16'd0);
        set_row(2, 16'd0, 16'd0, 16'd7);
        set_row(3, 16'd3, 16'd4, 16'd4);
        set_row(4, 16'hFFFE, 16'hFFFF, 16'hFFFB);
        set_row(5, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic load_extreme();
        set_row(0, 16'h8000, 16'h7FFF, 16'hFFFF);
        set_row(1, 16'hFFFD, 16'hFFFD, 16'hFFF9);
        set_row(2, 16'd0, 16'd0, 16'd1);
        set_row(3, 16'd5, 16'd1, 16'd1);
        set_row(4, 16'h7FFF, 16'h8000, 16'h7FFF);
        set_row(5, 16'hFFFE, 16'hFFFF, 16'hFFFD);
    endtask

    task automatic chk_classes(input string tag, input int exp_cls [N]);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("%s_class%0d", tag, n), 32'(classes[n]), 32'(exp_cls[n]));
        end
    endtask

    task automatic scan_rows(input string tag);
        for (int r = 0; r < N; r++) begin
            chk($sformatf("%s_index%0d", tag, r), 32'(index), 32'(r));
            chk($sformatf("%s_busy%0d", tag, r), 32'(done_argmax), 32'd0);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        done_comb = 1'b0;
        load_basic();
        repeat (2) tick();

        chk("rst_done", 32'(done_argmax), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk_classes("rst", '{0, 0, 0, 0, 0, 0});

        // Basic scan: done_argmax 6 edges after done_comb is first sampled.
        reset = 1'b1;
        tick();
        done_comb = 1'b1;
        tick();
        scan_rows("basic");
        chk("basic_done", 32'(done_argmax), 32'd1);
        chk("basic_idx_done", 32'(index), 32'd0);
        chk_classes("basic", '{1, 0, 2, 1, 1, 0});
`ifdef ARGMAX_MAXVAL_OUT_EN
        chk("maxv0", 32'(max_vals[0]), 32'h0005);
        chk("maxv1", 32'(max_vals[1]), 32'h0009);
        chk("maxv2", 32'(max_vals[2]), 32'h0007);
        chk("maxv3", 32'(max_vals[3]), 32'h0004);
        chk("maxv4", 32'(max_vals[4]), 32'hFFFF);
        chk("maxv5", 32'(max_vals[5]), 32'h0000);
`endif

        // Hold in DONE, then drop done_comb for one cycle.
        tick();
        chk("hold_done", 32'(done_argmax), 32'd1);
        done_comb = 1'b0;
        tick();
        chk("idle_done", 32'(done_argmax), 32'd0);
        chk("idle_index", 32'(index), 32'd0);
        chk("idle_keep_class0", 32'(classes[0]), 32'd1);

        // Restart with signed extremes and ties: results overwritten.
        load_extreme();
        done_comb = 1'b1;
        tick();
        scan_rows("restart");
        chk("restart_done", 32'(done_argmax), 32'd1);
        chk_classes("restart", '{1, 0, 2, 0, 0, 1});

        // One-cycle done_comb pulse still scans every row.
        done_comb = 1'b0;
        tick();
        chk("pulse_idle", 32'(done_argmax), 32'd0);
        load_basic();
        done_comb = 1'b1;
        tick();
        done_comb = 1'b0;
        scan_rows("pulse");
        chk("pulse_done", 32'(done_argmax), 32'd1);
        chk_classes("pulse", '{1, 0, 2, 1, 1, 0});
        tick();
        chk("pulse_back_idle", 32'(done_argmax), 32'd0);

        // Reset after three rows of a new scan clears everything at once.
        load_extreme();
        done_comb = 1'b1;
        tick();
        repeat (3) tick();
        chk("mid_class0_pre", 32'(classes[0]), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_done", 32'(done_argmax), 32'd0);
        chk("mid_rst_index", 32'(index), 32'd0);
        chk_classes("mid_rst", '{0, 0, 0, 0, 0, 0});

        // Release with done_comb still high: fresh scan from row 0.
        reset = 1'b1;
        tick();
        scan_rows("resume");
        chk("resume_done", 32'(done_argmax), 32'd1);
        chk_classes("resume", '{1, 0, 2, 0, 0, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
